// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU: ROM fetch, decode handshake, mem/reg strobes, branches.
// Latency: 5 cycles FETCH->FETCH for ALU/memory/NOP instructions, 3 cycles for JMP/BEQ; HALT is terminal until rst.
// No backpressure: ROM and data memory are assumed to accept a strobe every cycle it is driven.
module instr_sequencer #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_en,
   output logic [ADDR_W-1:0] pc_out,
   input  logic [7:0]        instr_rdata,
   output logic [3:0]        opcode,
   output logic [3:0]        operand,
   input  logic              dec_mem_read,
   input  logic              dec_mem_write,
   input  logic              dec_wb_mem,
   input  logic              dec_load_a,
   input  logic              dec_load_b,
   input  logic              dec_br_zero,
   input  logic              dec_br_eq,
   input  logic              alu_eq,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic              reg_a_we,
   output logic              reg_b_we,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_retired
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_LATCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [CNT_W-1:0]  ret_q, ret_d;

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_target;
   logic [CNT_W-1:0]  ret_inc;
   logic              run;

   // PC arithmetic wraps naturally at the register width
   assign pc_inc    = pc_q + ADDR_W'(1);
   assign pc_target = ADDR_W'(ir_q[3:0]);
   assign ret_inc   = ret_q + CNT_W'(1);
   // strobes are forced low while reset is held, whatever the state register holds
   assign run       = ~rst;

   assign pc_out        = pc_q;
   assign opcode        = ir_q[7:4];
   assign operand       = ir_q[3:0];
   assign instr_retired = ret_q;

   // next-state: instruction sequencing, branch resolution, retirement count
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ret_d   = ret_q;
      case (state_q)
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            ir_d    = instr_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (ir_q[7:4] == 4'hF) begin
               state_d = S_HALT;
            end else if (dec_br_zero) begin
               pc_d    = pc_target;
               ret_d   = ret_inc;
               state_d = S_FETCH;
            end else if (dec_br_eq) begin
               pc_d    = alu_eq ? pc_target : pc_inc;
               ret_d   = ret_inc;
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_MEM: state_d = S_WB;
         S_WB: begin
            pc_d    = pc_inc;
            ret_d   = ret_inc;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // state, PC, IR and retirement counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= 8'h00;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ret_q   <= ret_d;
      end
   end

   // strobes decoded from the state register qualified by the decoder outputs
   always_comb begin
      rom_en   = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      reg_a_we = 1'b0;
      reg_b_we = 1'b0;
      halted   = 1'b0;
      if (run) begin
         case (state_q)
            S_FETCH: rom_en = 1'b1;
            S_MEM: begin
               dmem_re = dec_mem_read | dec_wb_mem;
               dmem_we = dec_mem_write;
            end
            S_WB: begin
               dmem_we  = dec_wb_mem;
               reg_a_we = dec_load_a;
               reg_b_we = dec_load_b;
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: sync ROM + decoder model around the DUT, instruction-level reference.
// Latency: checks every cycle of every instruction against the expected cycle shape.
// No backpressure in this environment.
module tb_instr_sequencer;

   localparam int ADDR_W = 4;
   localparam int CNT_W  = 6;   // small counter so wrap-around is reachable quickly

   logic              clk = 1'b0;
   logic              rst;
   logic              rom_en;
   logic [ADDR_W-1:0] pc_out;
   logic [7:0]        instr_rdata;
   logic [3:0]        opcode;
   logic [3:0]        operand;
   logic              dec_mem_read, dec_mem_write, dec_wb_mem;
   logic              dec_load_a, dec_load_b, dec_br_zero, dec_br_eq;
   logic              alu_eq;
   logic              dmem_re, dmem_we, reg_a_we, reg_b_we, halted;
   logic [CNT_W-1:0]  instr_retired;
   logic [5:0]        strb_v;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]        rom [16];
   logic [ADDR_W-1:0] pc_m;
   logic [CNT_W-1:0]  ret_m;
   bit                hlt;

   always #5 clk = ~clk;

   instr_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .rom_en(rom_en), .pc_out(pc_out), .instr_rdata(instr_rdata),
      .opcode(opcode), .operand(operand),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_wb_mem(dec_wb_mem),
      .dec_load_a(dec_load_a), .dec_load_b(dec_load_b), .dec_br_zero(dec_br_zero),
      .dec_br_eq(dec_br_eq), .alu_eq(alu_eq),
      .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_a_we(reg_a_we), .reg_b_we(reg_b_we),
      .halted(halted), .instr_retired(instr_retired)
   );

   assign strb_v = {rom_en, dmem_re, dmem_we, reg_a_we, reg_b_we, halted};

   // Control decoder of the CPU: {mem_read, mem_write, wb_mem, load_a, load_b, br_zero, br_eq}
   function automatic logic [6:0] dec_of(input logic [3:0] op);
      case (op)
         4'h0, 4'h1, 4'h6, 4'h8: dec_of = 7'b0010000; // ADD/SUB/AND/OR: read mem, write back
         4'h2:                   dec_of = 7'b1001000; // LDA
         4'h3:                   dec_of = 7'b0100000; // STA
         4'h4:                   dec_of = 7'b1000100; // LDB
         4'h5:                   dec_of = 7'b0001000; // LDC (immediate to A)
         4'h7:                   dec_of = 7'b0000010; // JMP
         4'h9:                   dec_of = 7'b0000100; // LDBI (immediate to B)
         4'hA:                   dec_of = 7'b0000001; // BEQ
         default:                dec_of = 7'b0000000; // NOP / HALT
      endcase
   endfunction

   always_comb begin
      {dec_mem_read, dec_mem_write, dec_wb_mem, dec_load_a, dec_load_b, dec_br_zero, dec_br_eq} = dec_of(opcode);
   end

   // synchronous-read program ROM
   always @(posedge clk) begin
      if (rom_en) instr_rdata <= rom[pc_out];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic rand_rom();
      for (int i = 0; i < 16; i++) begin
         rom[i] = 8'($urandom);
         if (rom[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) rom[i][7:4] = 4'hC;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_strobes", 32'(strb_v), 32'h0);
      end
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_retired", 32'(instr_retired), 32'h0);
      chk("rst_ir", 32'({opcode, operand}), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      pc_m  = '0;
      ret_m = '0;
   endtask

   // Run one instruction from the model's PC; alu_mode 0/1 forces alu_eq, 2 randomizes it.
   task automatic run_instr(input int alu_mode, output bit halt_seen);
      logic [7:0] ins;
      logic [6:0] d;
      logic       eq;
      halt_seen = 1'b0;
      @(negedge clk);
      eq     = (alu_mode == 2) ? 1'($urandom_range(0, 1)) : (alu_mode == 1);
      alu_eq = eq;
      chk("fetch_strobes", 32'(strb_v), 32'b100000);
      chk("fetch_pc", 32'(pc_out), 32'(pc_m));
      chk("retired", 32'(instr_retired), 32'(ret_m));
      ins = rom[pc_m];
      d   = dec_of(ins[7:4]);
      @(negedge clk);
      chk("latch_strobes", 32'(strb_v), 32'h0);
      @(negedge clk);
      chk("exec_strobes", 32'(strb_v), 32'h0);
      chk("exec_ir", 32'({opcode, operand}), 32'(ins));
      if (ins[7:4] == 4'hF) begin
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_strobes", 32'(strb_v), 32'b000001);
            chk("halt_retired", 32'(instr_retired), 32'(ret_m));
         end
         halt_seen = 1'b1;
      end else if (ins[7:4] == 4'h7) begin
         pc_m  = ins[3:0];
         ret_m = ret_m + 1'b1;
      end else if (ins[7:4] == 4'hA) begin
         pc_m  = eq ? ins[3:0] : ADDR_W'(pc_m + 1'b1);
         ret_m = ret_m + 1'b1;
      end else begin
         @(negedge clk);
         chk("mem_strobes", 32'(strb_v), 32'({1'b0, d[6] | d[4], d[5], 3'b000}));
         chk("mem_addr", 32'(operand), 32'(ins[3:0]));
         chk("mem_re_we_excl", 32'(dmem_re & dmem_we), 32'h0);
         @(negedge clk);
         chk("wb_strobes", 32'(strb_v), 32'({2'b00, d[4], d[3], d[2], 1'b0}));
         chk("wb_re_we_excl", 32'(dmem_re & dmem_we), 32'h0);
         pc_m  = ADDR_W'(pc_m + 1'b1);
         ret_m = ret_m + 1'b1;
      end
   endtask

   initial begin
      rst         = 1'b1;
      alu_eq      = 1'b0;
      instr_rdata = 8'h00;

      // LDA 5
      rand_rom(); rom[0] = 8'h25;
      do_reset(); run_instr(0, hlt);
      // JMP 10, then fetch from 10
      rand_rom(); rom[0] = 8'h7A; rom[10] = 8'hB0;
      do_reset(); run_instr(0, hlt); run_instr(0, hlt);
      // BEQ 3 not taken, then taken
      rand_rom(); rom[0] = 8'hA3; rom[1] = 8'hC0; rom[3] = 8'hD0;
      do_reset(); run_instr(0, hlt); run_instr(0, hlt);
      do_reset(); run_instr(1, hlt); run_instr(0, hlt);
      // ADD 7 and LDC 4
      rand_rom(); rom[0] = 8'h07; rom[1] = 8'h54;
      do_reset(); run_instr(0, hlt); run_instr(0, hlt);
      // PC wrap via NOP at 15
      rand_rom(); rom[0] = 8'h7F; rom[15] = 8'hB0;
      do_reset(); run_instr(0, hlt); run_instr(0, hlt); run_instr(0, hlt);
      // HALT, first cold then after one retired NOP
      rand_rom(); rom[0] = 8'hF0;
      do_reset(); run_instr(0, hlt);
      chk("halt_flag", 32'(hlt), 32'h1);
      rom[0] = 8'hE0; rom[1] = 8'hF5;
      do_reset(); run_instr(0, hlt); run_instr(0, hlt);

      // reset hits during MEM of the second STA
      rand_rom(); rom[0] = 8'h34; rom[1] = 8'h34;
      do_reset(); run_instr(0, hlt);
      repeat (4) @(negedge clk);
      chk("sta_mem_we", 32'(dmem_we), 32'h1);
      rst = 1'b1;
      #1 chk("sta_rst_we", 32'(dmem_we), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      pc_m  = '0;
      ret_m = '0;
      run_instr(0, hlt);

      // retirement counter wraps
      for (int i = 0; i < 16; i++) rom[i] = 8'h70;
      do_reset();
      for (int i = 0; i < 70; i++) run_instr(0, hlt);

      // random programs
      for (int p = 0; p < 4; p++) begin
         rand_rom();
         do_reset();
         for (int i = 0; i < 60; i++) begin
            run_instr(2, hlt);
            if (hlt) break;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
